k6502_timing_decode: RTL
========================

// Module: k6502_timing_decode
// PURPOSE
//  Instruction register, cycle-timing (T-state) generator and decode logic for the k6502 core.
//  Sits directly upstream of the datapath: it consumes the pre-decode byte and produces every
//  datapath enable each ph0 cycle as one control_signals_t value.
//  One ph0 cycle = one bus cycle; all cycles are reads.
//  Supported opcodes:
//    A9/A2/A0  LDA/LDX/LDY #imm
//    A5/A6/A4  LDA/LDX/LDY zp
//    8A        TXA
//    98        TYA
//    EA        NOP
// PARAMETERS
//  RESET_OPCODE    8'hEA  value loaded into ir by reset.
//  ILLEGAL_AS_NOP  1      1: an unknown opcode runs as a 2-cycle NOP. 0: timing holds in T2 until reset.
// PORTS
//  ph0      in   1                  clock; all state updates on its rising edge.
//  reset    in   1                  synchronous, active-high reset.
//  rdy      in   1                  0 freezes all state; outputs are held.
//  pd       in   8                  pre-decode register output; sampled as opcode at the end of T1.
//  ctl      out  control_signals_t  datapath enables; combinational from (ir, t_state, wb).
//  t_state  out  3                  current cycle: 1 = T1 (opcode fetch), then 2, 3.
//  ir       out  8                  instruction register.
//  illegal  out  1                  high during T2 of an unknown opcode.
// BEHAVIOUR
//  Reset values: t_state=1, ir=RESET_OPCODE, wb=NONE, illegal=0.
//  ctl at reset: sync=1, pc_ab=1, pc_inc=1, all other fields 0.
//  T1 (every instruction):
//    - ctl: sync, pc_ab, pc_inc.
//    - at the rdy=1 edge: ir<=pd, t_state<=2.
//  Pending writeback (wb: NONE/A/X/Y):
//    - Set in an instruction's last cycle.
//    - Its fields are asserted in the following T1, overlapping the next fetch.
//    - Cleared at the end of that T1.
//  wb field sets:
//    - A: dl_db, ac_db
//    - X: dl_db, sb_db, sb_x
//    - Y: dl_db, sb_db, sb_y
//  Per-opcode cycle sequences:
//    - imm: T2 = pc_ab, pc_inc; set wb; next state T1. Total 2 cycles.
//    - zp:  T2 = pc_ab, pc_inc.
//           T3 = dl_adl, adl_abl, zero_adh, adh_abh (pc_inc=0); set wb; next state T1.
//           Total 3 cycles.
//    - TXA/TYA: T2 = x_sb|y_sb, ac_sb, pc_ab (dummy read, pc_inc=0); wb=NONE.
//    - NOP / illegal: T2 = pc_ab only; illegal=1 only for unknown opcodes.
//  rdy:
//    - rdy=0 holds t_state, ir and wb unchanged.
//    - ctl is repeated identically every stalled cycle.
//    - An unknown opcode with ILLEGAL_AS_NOP=0 keeps illegal=1.
//  Reset priority:
//    - Reset beats rdy.
//    - Reset mid-instruction (any T) returns to T1 next cycle and discards pending wb.
//  At most one of ac_db/ac_sb, and at most one bus driver per bus (x_sb/y_sb/add_sb, dl_*), in any cycle.
//  t_state never exceeds 3; an unreachable value recovers to T1.
// STRUCTURE
//  k6502_pkg (shared):
//    - control_signals_t, moved out of the core top-level and extended with pc_ab, pc_inc, zero_adh, sb_db, sync.
//    - opcode localparams.
//    - t_state_e enum.
//    - wb_sel_e enum.
//  Sub-module k6502_decode_rom: purely combinational (ir, t_state, wb) -> ctl, illegal.
//  Top level holds ir, the T-state counter and the wb register.
// TESTING
//  1. reset=1 for 2 cycles -> t_state=1, ir=EA, sync=pc_ab=pc_inc=1, all load/drive fields 0.
//  2. pd=A9 in T1, operand 42 -> T2: pc_ab, pc_inc. Next T1: sync, dl_db, ac_db; ac_sb=0.
//  3. pd=A6 -> T2: pc_inc=1; T3: dl_adl, adl_abl, zero_adh, adh_abh, pc_inc=0.
//     Next T1: dl_db, sb_db, sb_x.
//  4. pd=98 -> T2: y_sb, ac_sb, pc_inc=0. Following T1 has no wb fields.
//  5. rdy=0 for 3 cycles in T3 of A5 -> t_state stays 3, ctl bit-identical.
//     rdy=1 -> T1 with dl_db, ac_db.
//  6. pd=FF -> illegal=1 in T2 only, T1 next.
//     Reset asserted in T3 of A4 -> next cycle T1, no sb_y asserted.

Source files
------------

// File: rtl/k6502_pkg.sv
// k6502_pkg: shared control word, opcode constants and state enums for the k6502 core.
package k6502_pkg;
  typedef struct packed {
    logic sync;
    logic pc_ab;
    logic pc_inc;
    logic dl_db;
    logic ac_db;
    logic ac_sb;
    logic sb_db;
    logic sb_x;
    logic sb_y;
    logic x_sb;
    logic y_sb;
    logic add_sb;
    logic dl_adl;
    logic adl_abl;
    logic zero_adh;
    logic adh_abh;
  } control_signals_t;
  typedef enum logic [2:0] {T1 = 3'd1, T2 = 3'd2, T3 = 3'd3} t_state_e;
  typedef enum logic [1:0] {WB_NONE, WB_A, WB_X, WB_Y} wb_sel_e;
  typedef enum logic [2:0] {C_IMM, C_ZP, C_TXA, C_TYA, C_NOP, C_ILL} op_class_e;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDX_ZP  = 8'hA6;
  localparam logic [7:0] OP_LDY_ZP  = 8'hA4;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TYA     = 8'h98;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  function automatic op_class_e op_class(input logic [7:0] op);
    case (op)
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM: return C_IMM;
      OP_LDA_ZP, OP_LDX_ZP, OP_LDY_ZP:    return C_ZP;
      OP_TXA:                             return C_TXA;
      OP_TYA:                             return C_TYA;
      OP_NOP:                             return C_NOP;
      default:                            return C_ILL;
    endcase
  endfunction
  function automatic wb_sel_e op_dest(input logic [7:0] op);
    case (op)
      OP_LDA_IMM, OP_LDA_ZP: return WB_A;
      OP_LDX_IMM, OP_LDX_ZP: return WB_X;
      OP_LDY_IMM, OP_LDY_ZP: return WB_Y;
      default:               return WB_NONE;
    endcase
  endfunction
endpackage

// File: rtl/k6502_decode_rom.sv
// k6502_decode_rom: combinational decode of (ir, t_state, wb) into datapath enables.
module k6502_decode_rom
  import k6502_pkg::*;
(
  input  logic [7:0]       ir,
  input  t_state_e         t_state,
  input  wb_sel_e          wb,
  output control_signals_t ctl,
  output logic             illegal
);
  op_class_e cls;
  assign cls = op_class(ir);
  always_comb begin
    ctl = '0;
    illegal = 1'b0;
    case (t_state)
      T1: begin
        ctl.sync = 1'b1;
        ctl.pc_ab = 1'b1;
        ctl.pc_inc = 1'b1;
        // pending writeback completes on the buses while the next opcode is fetched
        ctl.dl_db = wb != WB_NONE;
        ctl.ac_db = wb == WB_A;
        ctl.sb_db = (wb == WB_X) || (wb == WB_Y);
        ctl.sb_x = wb == WB_X;
        ctl.sb_y = wb == WB_Y;
      end
      T2: begin
        ctl.pc_ab = 1'b1;
        ctl.pc_inc = (cls == C_IMM) || (cls == C_ZP);
        ctl.x_sb = cls == C_TXA;
        ctl.y_sb = cls == C_TYA;
        ctl.ac_sb = (cls == C_TXA) || (cls == C_TYA);
        illegal = cls == C_ILL;
      end
      T3: begin
        ctl.dl_adl = cls == C_ZP;
        ctl.adl_abl = cls == C_ZP;
        ctl.zero_adh = cls == C_ZP;
        ctl.adh_abh = cls == C_ZP;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/k6502_timing_decode.sv
// k6502_timing_decode: instruction register, T-state sequencer and pending writeback for the k6502.
module k6502_timing_decode
  import k6502_pkg::*;
#(
  parameter logic [7:0] RESET_OPCODE   = 8'hEA,
  parameter bit         ILLEGAL_AS_NOP = 1'b1
) (
  input  logic             ph0,
  input  logic             reset,
  input  logic             rdy,
  input  logic [7:0]       pd,
  output control_signals_t ctl,
  output logic [2:0]       t_state,
  output logic [7:0]       ir,
  output logic             illegal
);
  t_state_e t_q;
  wb_sel_e  wb;
  op_class_e cls;
  assign cls = op_class(ir);
  assign t_state = t_q;
  always_ff @(posedge ph0) begin
    if (reset) begin
      t_q <= T1;
      ir <= RESET_OPCODE;
      wb <= WB_NONE;
    end else if (rdy) begin
      case (t_q)
        T1: begin
          ir <= pd;
          t_q <= T2;
          wb <= WB_NONE;
        end
        T2: begin
          wb <= (cls == C_IMM) ? op_dest(ir) : WB_NONE;
          t_q <= (cls == C_ZP) ? T3 : (cls == C_ILL && !ILLEGAL_AS_NOP) ? T2 : T1;
        end
        T3: begin
          wb <= (cls == C_ZP) ? op_dest(ir) : WB_NONE;
          t_q <= T1;
        end
        default: t_q <= T1;
      endcase
    end
  end
  k6502_decode_rom u_rom (
    .ir(ir),
    .t_state(t_q),
    .wb(wb),
    .ctl(ctl),
    .illegal(illegal)
  );
endmodule
